// File: rtl/hs_cdc_rx_if.sv
// Handshake bundle for hs_cdc_rx: source-side req/ack/data plus the downstream valid/ready port.
// The slave modport is the receiver; master is whoever drives the source and downstream sides.
interface hs_cdc_rx_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  req_async;
   logic [DATA_WIDTH-1:0] data_async;
   logic                  ack;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [DATA_WIDTH-1:0] dout_data;

   modport master (
      output req_async, data_async, dout_ready,
      input  ack, dout_valid, dout_data
   );

   modport slave (
      input  req_async, data_async, dout_ready,
      output ack, dout_valid, dout_data
   );
endinterface

// File: rtl/hs_cdc_rx.sv
// Destination end of a 4-phase req/ack CDC handshake: synchronizes req, captures the
// source-held word, offers it on valid/ready and returns a registered level ack.
module hs_cdc_rx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SYNC_STAGE = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hs_cdc_rx_if.slave           bus,
   output logic                 busy,
   output logic                 proto_err,
   output logic [CNT_WIDTH-1:0] xfer_cnt
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OUT  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [SYNC_STAGE-1:0] sync_q;
   logic                  req_s;
   logic [1:0]            state_q, state_d;
   logic                  ack_q, ack_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   // Only the synchronizer may look at req_async.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGE-2:0], bus.req_async};
      end
   end

   assign req_s = sync_q[SYNC_STAGE-1];

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            // data_async has been stable for SYNC_STAGE cycles once req_s is seen.
            if (req_s) begin
               data_d  = bus.data_async;
               valid_d = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (!req_s) err_d = 1'b1;
            if (bus.dout_ready) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               state_d = ACK;
            end
         end
         ACK: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.dout_valid = valid_q;
   assign bus.dout_data  = data_q;
   assign busy           = (state_q != IDLE);
   assign proto_err      = err_q;
   assign xfer_cnt       = cnt_q;
endmodule

// File: tb/tb_hs_cdc_rx.sv
// Scoreboard bench for hs_cdc_rx: directed source/downstream stimulus pushes expected words,
// a negedge monitor pops them on every accepted handshake. A 2-bit-counter copy runs in lockstep.
module tb_hs_cdc_rx;
   logic        clk;
   logic        rst_n;
   logic        busy, proto_err, busy2, proto_err2;
   logic [15:0] xfer_cnt;
   logic [1:0]  xfer_cnt2;

   hs_cdc_rx_if #(.DATA_WIDTH(8)) ifa ();
   hs_cdc_rx_if #(.DATA_WIDTH(8)) ifb ();

   assign ifb.req_async  = ifa.req_async;
   assign ifb.data_async = ifa.data_async;
   assign ifb.dout_ready = ifa.dout_ready;

   hs_cdc_rx #(.DATA_WIDTH(8), .SYNC_STAGE(2), .CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifa.slave),
      .busy      (busy),
      .proto_err (proto_err),
      .xfer_cnt  (xfer_cnt)
   );

   hs_cdc_rx #(.DATA_WIDTH(8), .SYNC_STAGE(2), .CNT_WIDTH(2)) dut_w (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifb.slave),
      .busy      (busy2),
      .proto_err (proto_err2),
      .xfer_cnt  (xfer_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         exp_cnt  = 0;
   logic [7:0] exp_q[$];
   logic       prev_v   = 1'b0;
   logic [7:0] prev_d   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: the DUT commits the handshake on the following posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_cnt = 0;
         prev_v  = 1'b0;
      end else begin
         if (prev_v && ifa.dout_valid) check("data_hold", {24'd0, ifa.dout_data}, {24'd0, prev_d});
         if (ifa.dout_valid && ifa.dout_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h, expected none", ifa.dout_data);
            end else begin
               check("sb_data", {24'd0, ifa.dout_data}, {24'd0, exp_q.pop_front()});
            end
            check("sb_cnt", {16'd0, xfer_cnt}, exp_cnt);
            exp_cnt++;
            prev_v = 1'b0;
         end else begin
            prev_v = ifa.dout_valid;
            prev_d = ifa.dout_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic lvl, input string name);
      int n = 0;
      while (ifa.ack !== lvl && n < 40) begin
         tick(1);
         n++;
      end
      check(name, {31'd0, ifa.ack}, {31'd0, lvl});
   endtask

   task automatic do_reset();
      ifa.req_async = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   // Behavioural 4-phase source.
   task automatic src_xfer(input logic [7:0] d);
      ifa.data_async = d;
      ifa.req_async  = 1'b1;
      exp_q.push_back(d);
      wait_ack(1'b1, "src_ack_rise");
      ifa.req_async = 1'b0;
      wait_ack(1'b0, "src_ack_fall");
   endtask

   logic [1:0] wrap_exp [5];

   initial begin
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst_n = 1'b0;
      ifa.req_async  = 1'b0;
      ifa.data_async = 8'h00;
      ifa.dout_ready = 1'b0;
      #1;
      check("rst_ack", {31'd0, ifa.ack}, 0);
      check("rst_valid", {31'd0, ifa.dout_valid}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_err", {31'd0, proto_err}, 0);
      check("rst_data", {24'd0, ifa.dout_data}, 0);
      check("rst_cnt", {16'd0, xfer_cnt}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single transfer, ready held high.
      ifa.dout_ready = 1'b1;
      ifa.data_async = 8'hA5;
      ifa.req_async  = 1'b1;
      exp_q.push_back(8'hA5);
      tick(2);
      check("single_valid_early", {31'd0, ifa.dout_valid}, 0);
      tick(1);
      check("single_valid", {31'd0, ifa.dout_valid}, 1);
      check("single_data", {24'd0, ifa.dout_data}, 32'hA5);
      check("single_busy", {31'd0, busy}, 1);
      tick(1);
      check("single_ack", {31'd0, ifa.ack}, 1);
      check("single_valid_drop", {31'd0, ifa.dout_valid}, 0);
      ifa.req_async = 1'b0;
      tick(2);
      check("single_ack_hold", {31'd0, ifa.ack}, 1);
      tick(1);
      check("single_ack_fall", {31'd0, ifa.ack}, 0);
      check("single_idle", {31'd0, busy}, 0);
      check("single_cnt", {16'd0, xfer_cnt}, 1);

      // Backpressure.
      ifa.dout_ready = 1'b0;
      ifa.data_async = 8'h3C;
      ifa.req_async  = 1'b1;
      exp_q.push_back(8'h3C);
      tick(3);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", {31'd0, ifa.dout_valid}, 1);
         check("bp_data", {24'd0, ifa.dout_data}, 32'h3C);
         check("bp_ack", {31'd0, ifa.ack}, 0);
         tick(1);
      end
      ifa.dout_ready = 1'b1;
      tick(1);
      ifa.dout_ready = 1'b0;
      check("bp_ack_rise", {31'd0, ifa.ack}, 1);
      check("bp_valid_fall", {31'd0, ifa.dout_valid}, 0);
      ifa.req_async = 1'b0;
      wait_ack(1'b0, "bp_ack_fall");
      check("bp_cnt", {16'd0, xfer_cnt}, 2);

      // Back-to-back through the source model.
      do_reset();
      ifa.dout_ready = 1'b1;
      for (int i = 1; i <= 4; i++) src_xfer(8'(i));
      check("b2b_cnt", {16'd0, xfer_cnt}, 4);
      check("b2b_err", {31'd0, proto_err}, 0);
      check("b2b_sb_empty", exp_q.size(), 0);

      // Protocol error: req dropped while word is still pending.
      ifa.dout_ready = 1'b0;
      ifa.data_async = 8'h5A;
      ifa.req_async  = 1'b1;
      exp_q.push_back(8'h5A);
      tick(3);
      check("perr_valid", {31'd0, ifa.dout_valid}, 1);
      ifa.req_async = 1'b0;
      tick(3);
      check("perr_set", {31'd0, proto_err}, 1);
      check("perr_still_valid", {31'd0, ifa.dout_valid}, 1);
      check("perr_no_ack", {31'd0, ifa.ack}, 0);
      ifa.dout_ready = 1'b1;
      tick(1);
      check("perr_ack_pulse", {31'd0, ifa.ack}, 1);
      tick(1);
      check("perr_ack_one", {31'd0, ifa.ack}, 0);
      check("perr_idle", {31'd0, busy}, 0);
      tick(5);
      check("perr_sticky", {31'd0, proto_err}, 1);
      check("perr_cnt", {16'd0, xfer_cnt}, 5);

      // Reset while in ACK, then release with req still high.
      do_reset();
      check("rst2_err", {31'd0, proto_err}, 0);
      ifa.data_async = 8'h77;
      ifa.req_async  = 1'b1;
      exp_q.push_back(8'h77);
      tick(4);
      check("mid_in_ack", {31'd0, ifa.ack}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_ack", {31'd0, ifa.ack}, 0);
      check("mid_valid", {31'd0, ifa.dout_valid}, 0);
      check("mid_busy", {31'd0, busy}, 0);
      check("mid_cnt", {16'd0, xfer_cnt}, 0);
      exp_q.push_back(8'h77);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check("rel_valid_early", {31'd0, ifa.dout_valid}, 0);
      tick(1);
      check("rel_valid", {31'd0, ifa.dout_valid}, 1);
      check("rel_data", {24'd0, ifa.dout_data}, 32'h77);
      ifa.req_async = 1'b0;
      wait_ack(1'b1, "rel_ack_rise");
      wait_ack(1'b0, "rel_ack_fall");
      check("rel_cnt", {16'd0, xfer_cnt}, 1);

      // Counter wrap on the 2-bit instance.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         src_xfer(8'h10 + 8'(i));
         check("wrap_cnt", {30'd0, xfer_cnt2}, {30'd0, wrap_exp[i]});
      end
      check("wrap_err", {31'd0, proto_err2}, 0);
      tick(2);
      check("final_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hs_cdc_rx.md
Name: hs_cdc_rx

Overview:
- Destination-side endpoint of a 4-phase req/ack CDC handshake, running entirely in the destination clock domain.
- Synchronizes an asynchronous level request and captures the multi-bit data held stable by the source.
- Presents the captured word downstream on a valid/ready interface.
- Returns a registered level acknowledge to the source domain once the word has been accepted downstream.

Parameters:
DATA_WIDTH, 8, width of the transferred word
SYNC_STAGE, 2, flop count of the req synchronizer; legal range 2..4
CNT_WIDTH, 16, width of the completed-transfer counter

Ports:
clk  input  1  destination clock
rst_n  input  1  asynchronous active-low reset
req_async  input  1  level request from the source domain; high = data valid and stable
data_async  input  DATA_WIDTH  source data; stable from the req rise until ack is seen high at the source
ack  output  1  registered level acknowledge back to the source domain
dout_valid  output  1  captured word available downstream
dout_ready  input  1  downstream accepts the word when high together with dout_valid
dout_data  output  DATA_WIDTH  captured word; constant while dout_valid is high
busy  output  1  high whenever the FSM is not in IDLE
proto_err  output  1  sticky flag: req dropped before ack was issued
xfer_cnt  output  CNT_WIDTH  count of completed transfers; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async assert, sync release): every flop is cleared.
  - ack, dout_valid, busy, proto_err = 0; dout_data = 0; xfer_cnt = 0; synchronizer = 0; state = IDLE.
- req synchronizer: SYNC_STAGE-flop shift register on req_async; req_s is the last stage. No other logic samples req_async directly.
- data_async is never synchronized. It is sampled only in IDLE when req_s = 1. The protocol guarantees it has been stable for at least SYNC_STAGE cycles at that point.
- FSM states: IDLE, OUT, ACK.
  - IDLE: when req_s = 1, register dout_data <= data_async and dout_valid <= 1, then go to OUT. Otherwise stay.
  - OUT: hold dout_valid and dout_data. On dout_valid & dout_ready: dout_valid <= 0, ack <= 1, xfer_cnt <= xfer_cnt + 1, go to ACK.
  - ACK: hold ack = 1. When req_s = 0: ack <= 0, go to IDLE.
- Latency (req_async rises just before edge 0):
  - req_s high after edge SYNC_STAGE-1.
  - dout_valid high after edge SYNC_STAGE.
  - With dout_ready held high, ack rises one edge after the first dout_valid cycle.
- Ack release: ack falls one edge after req_s is observed low, i.e. SYNC_STAGE+1 edges after req_async falls.
- busy = (state != IDLE), decoded combinationally from the state register.
- No double capture: IDLE is re-entered only with req_s = 0. A new transfer requires a fresh req rise, which the source cannot issue until it sees ack low.
- Protocol violation, req_s = 0 while in OUT:
  - proto_err <= 1, held until reset.
  - The transfer still completes: the word stays valid until accepted.
  - ack then pulses high for exactly one cycle (ACK sees req_s = 0 immediately) and the FSM returns to IDLE.
- dout_ready while dout_valid = 0 is ignored.
- Simultaneous events:
  - An acceptance in OUT on the same edge that req_s falls still sets proto_err.
  - The transfer counts normally.
- Counter: xfer_cnt wraps from all-ones to 0 with no flag.
- Reset mid-operation: all outputs clear immediately on rst_n low.
  - If req_async is still high after release, it is treated as a new request and data is recaptured.
  - This is acceptable; the source is reset in the same reset tree.

Test Plan:
- Single transfer, SYNC_STAGE = 2, dout_ready held 1: data 0xA5 with req rise → dout_valid high 2 cycles later with dout_data = 0xA5; ack high one cycle after; drop req → ack low 3 cycles later; xfer_cnt = 1.
- Backpressure: dout_ready = 0 for 10 cycles → dout_valid and dout_data = 0x3C stay constant and ack stays 0; ready high for 1 cycle → ack rises next edge and dout_valid falls.
- Back-to-back: 4 transfers 0x01..0x04 driven by a behavioural 4-phase source model → exactly 4 dout_valid & dout_ready handshakes in order, no duplicates, xfer_cnt = 4, proto_err = 0.
- Protocol error: req dropped while dout_valid = 1 and ready = 0 → proto_err = 1 stays set; on later acceptance, ack is high for exactly 1 cycle; state returns to IDLE.
- Reset mid-transfer: assert rst_n low while in ACK → ack, dout_valid, busy, xfer_cnt are 0 asynchronously. Release with req held high → new capture, dout_valid rises after SYNC_STAGE+1 edges.
- Counter wrap: CNT_WIDTH = 2, 5 transfers → xfer_cnt sequence 1, 2, 3, 0, 1.
